// File: rtl/present_job_sequencer.sv
// present_job_sequencer: shares one PRESENT cipher core between two requesters.
// Port 0 is the bus register front-end, port 1 the DMA/stream engine. One 64-bit
// block job is accepted per grant (round-robin on ties), the core is loaded and
// watched by a watchdog, and the result or an abort is returned to the owner.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no job; arbitrate and grant, latching the job into core_* regs
// LOAD     | one-cycle core_load pulse, watchdog cleared
// WAIT     | waiting for core_done, watchdog counting
// RECOVER  | core hung: core_rst_n held low for one cycle
// RESP     | rsp valid to owner until the owner takes it
module present_job_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             iReset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [79:0]      req0_key,
  input  logic [63:0]      req0_data,
  input  logic             req0_decrypt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [79:0]      req1_key,
  input  logic [63:0]      req1_data,
  input  logic             req1_decrypt,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [63:0]      rsp0_data,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [63:0]      rsp1_data,
  output logic             rsp1_err,
  output logic             core_rst_n,
  output logic             core_load,
  output logic             core_control,
  output logic [79:0]      core_key,
  output logic [63:0]      core_data,
  input  logic [63:0]      core_odat,
  input  logic             core_done,
  output logic             busy,
  output logic             owner,
  output logic [CNT_W-1:0] jobs_done
);

  // Watchdog wide enough to reach TIMEOUT_CYCLES-1, its terminal count.
  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RECOVER = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [79:0]      key_q, key_d;
  logic [63:0]      data_q, data_d;
  logic             ctrl_q, ctrl_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic [63:0]      rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0] jobs_q, jobs_d;
  logic             core_rst_n_q, core_rst_n_d;

  logic             grant_vld;
  logic             grant_port;
  logic             rsp_hs;

  assign rsp_hs = (state_q == ST_RESP) && (owner_q ? rsp1_ready : rsp0_ready);

  // Next-state, arbitration and job/result capture.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    key_d        = key_q;
    data_d       = data_q;
    ctrl_d       = ctrl_q;
    wdog_d       = wdog_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    jobs_d       = jobs_q;
    grant_vld    = 1'b0;
    grant_port   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Gated by reset so no ready escapes while the block is held in reset.
        if (iReset_n && (req0_valid || req1_valid)) begin
          grant_vld    = 1'b1;
          grant_port   = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
          owner_d      = grant_port;
          last_grant_d = grant_port;
          key_d        = grant_port ? req1_key     : req0_key;
          data_d       = grant_port ? req1_data    : req0_data;
          ctrl_d       = grant_port ? req1_decrypt : req0_decrypt;
          state_d      = ST_LOAD;
        end
      end
      ST_LOAD: begin
        wdog_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A done seen on the terminal-count cycle still counts as success.
        if (core_done) begin
          rsp_data_d = core_odat;
          rsp_err_d  = 1'b0;
          jobs_d     = jobs_q + CNT_W'(1);
          state_d    = ST_RESP;
        end else if (wdog_q == WD_LAST) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = ST_RECOVER;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      ST_RECOVER: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_hs) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    core_rst_n_d = (state_d != ST_RECOVER);
  end

  // State and datapath registers; reset leaves the core held in reset.
  always_ff @(posedge clk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      key_q        <= '0;
      data_q       <= '0;
      ctrl_q       <= 1'b0;
      wdog_q       <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      jobs_q       <= '0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      key_q        <= key_d;
      data_q       <= data_d;
      ctrl_q       <= ctrl_d;
      wdog_q       <= wdog_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      jobs_q       <= jobs_d;
      core_rst_n_q <= core_rst_n_d;
    end
  end

  assign req0_ready   = grant_vld & ~grant_port;
  assign req1_ready   = grant_vld &  grant_port;

  assign rsp0_valid   = (state_q == ST_RESP) & ~owner_q;
  assign rsp1_valid   = (state_q == ST_RESP) &  owner_q;
  assign rsp0_data    = owner_q ? '0 : rsp_data_q;
  assign rsp1_data    = owner_q ? rsp_data_q : '0;
  assign rsp0_err     = ~owner_q & rsp_err_q;
  assign rsp1_err     =  owner_q & rsp_err_q;

  assign core_rst_n   = core_rst_n_q;
  assign core_load    = (state_q == ST_LOAD);
  assign core_control = ctrl_q;
  assign core_key     = key_q;
  assign core_data    = data_q;

  assign busy         = (state_q != ST_IDLE);
  assign owner        = owner_q;
  assign jobs_done    = jobs_q;

endmodule

// File: tb/tb_present_job_sequencer.sv
// Directed bench for present_job_sequencer with a small behavioural core model.
module tb_present_job_sequencer;
  localparam int TO = 64;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          iReset_n;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [79:0]   req0_key, req1_key;
  logic [63:0]   req0_data, req1_data;
  logic          req0_decrypt, req1_decrypt;
  logic          rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [63:0]   rsp0_data, rsp1_data;
  logic          rsp0_err, rsp1_err;
  logic          core_rst_n, core_load, core_control, core_done;
  logic [79:0]   core_key;
  logic [63:0]   core_data, core_odat;
  logic          busy, owner;
  logic [CW-1:0] jobs_done;

  present_job_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .iReset_n(iReset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_key(req0_key),
    .req0_data(req0_data), .req0_decrypt(req0_decrypt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_key(req1_key),
    .req1_data(req1_data), .req1_decrypt(req1_decrypt),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .core_rst_n(core_rst_n), .core_load(core_load), .core_control(core_control),
    .core_key(core_key), .core_data(core_data), .core_odat(core_odat), .core_done(core_done),
    .busy(busy), .owner(owner), .jobs_done(jobs_done)
  );

  // Core stand-in: the zero-key/zero-block encrypt gives the PRESENT-80 reference
  // vector; other jobs use an easily hand-computed mix that depends on control.
  function automatic logic [63:0] fn(input logic [79:0] k, input logic [63:0] d, input logic dec);
    if (k == '0 && d == '0 && !dec) return 64'h5579C1387B228445;
    else if (dec) return d ^ k[79:16];
    else return d ^ k[63:0] ^ 64'hA5A5_5A5A_0F0F_F0F0;
  endfunction

  int          mdl_delay;
  logic        mdl_never;
  logic        mdl_act, mdl_done;
  int          mdl_cnt;
  logic [63:0] mdl_odat;
  logic        spur_done;
  logic [63:0] spur_odat;

  assign core_done = mdl_done | spur_done;
  assign core_odat = spur_done ? spur_odat : mdl_odat;

  always @(negedge clk) begin
    mdl_done <= 1'b0;
    if (!core_rst_n) begin
      mdl_act <= 1'b0;
    end else if (core_load) begin
      mdl_act  <= !mdl_never;
      mdl_cnt  <= mdl_delay;
      mdl_odat <= fn(core_key, core_data, core_control);
    end else if (mdl_act) begin
      if (mdl_cnt <= 1) begin
        mdl_done <= 1'b1;
        mdl_act  <= 1'b0;
      end else begin
        mdl_cnt <= mdl_cnt - 1;
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    iReset_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    spur_done = 1'b0;
    repeat (2) @(negedge clk);
    iReset_n = 1'b1;
    @(negedge clk);
  endtask

  // Call at a negedge; returns at the negedge of the LOAD cycle with valid dropped.
  task automatic start_job(input logic p, input logic [79:0] k, input logic [63:0] d,
                           input logic dec, input string tag);
    logic g;
    g = 1'b0;
    if (p) begin req1_key = k; req1_data = d; req1_decrypt = dec; req1_valid = 1'b1; end
    else   begin req0_key = k; req0_data = d; req0_decrypt = dec; req0_valid = 1'b1; end
    for (int i = 0; i < 20 && !g; i++) begin
      #1;
      if (p ? req1_ready : req0_ready) g = 1'b1;
      else @(negedge clk);
    end
    chk({tag, "_grant"}, g, 1);
    @(negedge clk);
    if (p) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  localparam logic [79:0] K0 = 80'h0123_4567_89AB_CDEF_1357;
  localparam logic [79:0] K1 = 80'hFEDC_BA98_7654_3210_2468;
  localparam logic [79:0] K2 = 80'h1111_2222_3333_4444_5555;
  localparam logic [79:0] K3 = 80'h0000_0000_0000_0000_FFFF;
  localparam logic [63:0] D0 = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] D1 = 64'h0F0F_0F0F_1234_5678;
  localparam logic [63:0] D2 = 64'hCAFE_F00D_8765_4321;
  localparam logic [63:0] D3 = 64'h0000_0000_0000_00AA;

  initial begin
    logic       got, gotg, w, bad;
    int         loads, tl, tr, lows;
    logic [3:0] exp_ord;
    logic [63:0] held;

    iReset_n = 1'b0;
    req0_valid = 0; req1_valid = 0; req0_key = '0; req1_key = '0;
    req0_data = '0; req1_data = '0; req0_decrypt = 0; req1_decrypt = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    spur_done = 0; spur_odat = '0;
    mdl_delay = 4; mdl_never = 0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_core_rst_n", core_rst_n, 0);
    chk("rst_core_load", core_load, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_jobs", jobs_done, 0);
    chk("rst_owner", owner, 0);
    chk("rst_core_key", core_key, 0);
    @(negedge clk);
    iReset_n = 1'b1;
    @(negedge clk);
    #1;
    chk("core_rst_n_release", core_rst_n, 1);

    // 1: single encrypt on port 0, done after 32 cycles
    @(negedge clk);
    mdl_delay = 32;
    req0_key = '0; req0_data = '0; req0_decrypt = 0; req0_valid = 1;
    #1;
    chk("t1_ready0", req0_ready, 1);
    chk("t1_ready1", req1_ready, 0);
    @(negedge clk);
    req0_valid = 0;
    #1;
    chk("t1_load", core_load, 1);
    chk("t1_control", core_control, 0);
    loads = 0; got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk); #1;
      if (core_load) loads++;
      if (rsp0_valid) got = 1;
    end
    chk("t1_rsp_seen", got, 1);
    chk("t1_extra_loads", loads, 0);
    chk("t1_data", rsp0_data, 64'h5579C1387B228445);
    chk("t1_err", rsp0_err, 0);
    chk("t1_jobs", jobs_done, 1);
    chk("t1_rsp1_quiet", rsp1_valid, 0);
    rsp0_ready = 1;
    @(negedge clk); #1;
    chk("t1_rsp_drop", rsp0_valid, 0);
    chk("t1_idle", busy, 0);
    rsp0_ready = 0;

    // 2: both ports valid continuously, alternating grants 0,1,0,1
    do_reset();
    mdl_delay = 3;
    exp_ord = 4'b1010;
    req0_key = K0; req0_data = D0; req0_decrypt = 0;
    req1_key = K1; req1_data = D1; req1_decrypt = 1;
    req0_valid = 1; req1_valid = 1;
    rsp0_ready = 1; rsp1_ready = 1;
    for (int j = 0; j < 4; j++) begin
      gotg = 0;
      for (int i = 0; i < 20 && !gotg; i++) begin
        #1;
        if (req0_ready || req1_ready) gotg = 1;
        else @(negedge clk);
      end
      chk("t2_grant_seen", gotg, 1);
      chk("t2_one_ready", req0_ready && req1_ready, 0);
      chk("t2_winner", req1_ready, exp_ord[j]);
      w = req1_ready;
      got = 0;
      for (int i = 0; i < 50 && !got; i++) begin
        @(negedge clk); #1;
        if (rsp0_valid || rsp1_valid) got = 1;
      end
      chk("t2_rsp_seen", got, 1);
      chk("t2_rsp_owner", rsp1_valid, w);
      chk("t2_rsp_excl", rsp0_valid && rsp1_valid, 0);
      chk("t2_data", w ? rsp1_data : rsp0_data, w ? fn(K1, D1, 1) : fn(K0, D0, 0));
      @(negedge clk);
    end
    req0_valid = 0; req1_valid = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("t2_jobs", jobs_done, 4);

    // 3: core never finishes -> watchdog abort through RECOVER
    @(negedge clk);
    mdl_never = 1;
    start_job(1, K2, D2, 0, "t3");
    #1;
    chk("t3_load", core_load, 1);
    tl = cyc; tr = 0; lows = 0; got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk); #1;
      if (!core_rst_n) lows++;
      if (rsp1_valid) begin got = 1; tr = cyc; end
    end
    chk("t3_rsp_seen", got, 1);
    chk("t3_latency", tr - tl, TO + 2);
    chk("t3_core_rst_low", lows, 1);
    chk("t3_err", rsp1_err, 1);
    chk("t3_data", rsp1_data, 0);
    chk("t3_jobs", jobs_done, 4);
    chk("t3_rsp0_quiet", rsp0_valid, 0);
    rsp1_ready = 1;
    @(negedge clk);
    rsp1_ready = 0;

    // 4: port 0 holds off its response; port 1 waits; spurious done in RESP
    mdl_never = 0; mdl_delay = 5;
    start_job(0, K3, D3, 0, "t4");
    req1_key = K1; req1_data = D1; req1_decrypt = 1; req1_valid = 1;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk); #1;
      if (rsp0_valid) got = 1;
    end
    chk("t4_rsp_seen", got, 1);
    held = rsp0_data;
    chk("t4_data", held, fn(K3, D3, 0));
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      spur_odat = 64'h1234_1234_1234_1234;
      spur_done = (i == 10);
      #1;
      if (!rsp0_valid || rsp0_data !== held || rsp0_err || req1_ready) bad = 1;
    end
    spur_done = 0;
    chk("t4_held_stable", bad, 0);
    chk("t4_jobs", jobs_done, 5);
    rsp0_ready = 1;
    @(negedge clk);
    rsp0_ready = 0;
    #1;
    chk("t4_rsp0_drop", rsp0_valid, 0);
    chk("t4_port1_granted", req1_ready, 1);
    @(negedge clk);
    req1_valid = 0;
    rsp1_ready = 1;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk); #1;
      if (rsp1_valid) got = 1;
    end
    chk("t4_rsp1_seen", got, 1);
    chk("t4_rsp1_data", rsp1_data, fn(K1, D1, 1));
    @(negedge clk);
    rsp1_ready = 0;
    #1;
    chk("t4_jobs_after", jobs_done, 6);

    // 5: asynchronous reset while waiting on the core
    @(negedge clk);
    mdl_delay = 40;
    start_job(0, K0, D0, 0, "t5");
    repeat (3) @(negedge clk);
    iReset_n = 0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_core_rst_n", core_rst_n, 0);
    chk("t5_jobs", jobs_done, 0);
    chk("t5_core_key", core_key, 0);
    chk("t5_core_data", core_data, 0);
    chk("t5_rsp0", rsp0_valid, 0);
    repeat (2) @(negedge clk);
    iReset_n = 1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (rsp0_valid || rsp1_valid || busy) bad = 1;
    end
    chk("t5_no_rsp", bad, 0);
    mdl_delay = 4;
    start_job(1, K2, D2, 0, "t5b");
    rsp1_ready = 1;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk); #1;
      if (rsp1_valid) got = 1;
    end
    chk("t5_clean_seen", got, 1);
    chk("t5_clean_data", rsp1_data, fn(K2, D2, 0));
    chk("t5_clean_err", rsp1_err, 0);
    @(negedge clk);
    rsp1_ready = 0;
    #1;
    chk("t5_clean_jobs", jobs_done, 1);

    // 6: spurious done in IDLE, then done on the terminal watchdog cycle
    @(negedge clk);
    spur_odat = 64'h5555_AAAA_5555_AAAA;
    spur_done = 1;
    @(negedge clk);
    spur_done = 0;
    #1;
    chk("t6_idle_busy", busy, 0);
    chk("t6_idle_rsp", rsp0_valid | rsp1_valid, 0);
    chk("t6_idle_jobs", jobs_done, 1);
    @(negedge clk);
    mdl_never = 1;
    start_job(0, K3, D3, 0, "t6");
    repeat (TO) @(negedge clk);
    spur_odat = 64'hC0FF_EE00_1122_3344;
    spur_done = 1;
    @(negedge clk);
    spur_done = 0;
    #1;
    chk("t6_coinc_valid", rsp0_valid, 1);
    chk("t6_coinc_err", rsp0_err, 0);
    chk("t6_coinc_data", rsp0_data, 64'hC0FF_EE00_1122_3344);
    chk("t6_coinc_jobs", jobs_done, 2);
    rsp0_ready = 1;
    @(negedge clk);
    rsp0_ready = 0;
    #1;
    chk("t6_final_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: observed simulation still running expected finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
